// File: rtl/wb_trace_buffer_pkg.sv
// Shared field widths, trace entry layout and capture-filter helper for the
// writeback trace buffer.
package wb_trace_buffer_pkg;

    localparam int unsigned TRACE_PC_W    = 32;
    localparam int unsigned TRACE_ADDR_W  = 5;
    localparam int unsigned TRACE_DATA_W  = 32;
    localparam int unsigned TRACE_SEQ_W   = 16;
    localparam int unsigned TRACE_ENTRY_W = TRACE_PC_W + TRACE_ADDR_W + TRACE_DATA_W + TRACE_SEQ_W;

    // One captured register write as stored in the FIFO
    typedef struct packed {
        logic [TRACE_PC_W-1:0]   pc;
        logic [TRACE_ADDR_W-1:0] addr;
        logic [TRACE_DATA_W-1:0] wdata;
        logic [TRACE_SEQ_W-1:0]  seq;
    } trace_entry_t;

    // A commit is captured when gated on, a write strobe is present, and it is
    // not a filtered write to $0
    function automatic logic capture_ok(
        input logic                    enable,
        input logic                    wen,
        input logic [TRACE_ADDR_W-1:0] addr,
        input logic                    filter_r0
    );
        return enable & wen & ~(filter_r0 & (addr == TRACE_ADDR_W'(0)));
    endfunction

endpackage

// File: rtl/wb_trace_buffer_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with registered head, occupancy,
// full and almost-full flags.
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   flush_i         synchronous flush, wins over push/pop
//   push_i, wdata_i write request and data (ignored when full unless popping)
//   pop_i           consume the head entry (ignored when empty)
//   valid_o         FIFO non-empty
//   rdata_o         head entry, zero when empty
//   full_o, af_o    occupancy == DEPTH, occupancy >= AF_LEVEL
//   count_o         occupancy 0..DEPTH
module wb_trace_buffer_sync_fifo #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned AF_LEVEL = 14
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     af_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] head_q, head_d;
    logic             valid_q, valid_d;
    logic             full_q, full_d;
    logic             af_q, af_d;
    logic             push_ok, pop_ok;

    // A pop frees a slot in the same cycle, so push into a full FIFO is fine then
    assign pop_ok  = pop_i & valid_q & ~flush_i;
    assign push_ok = push_i & (~full_q | pop_ok) & ~flush_i;

    // Storage array; contents need no reset since the head register masks them
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Next pointers, occupancy and the head entry as seen after this edge
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        head_d   = head_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
            head_d   = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            cnt_d = cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
            // The new head is the word being written when it lands in the head slot
            if (cnt_d == '0) begin
                head_d = '0;
            end else if (push_ok && (rd_ptr_d == wr_ptr_q)) begin
                head_d = wdata_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
        valid_d = (cnt_d != '0);
        full_d  = (cnt_d == CNT_W'(DEPTH));
        af_d    = (cnt_d >= CNT_W'(AF_LEVEL));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
            full_q   <= full_d;
            af_q     <= af_d;
        end
    end

    assign valid_o = valid_q;
    assign rdata_o = head_q;
    assign full_o  = full_q;
    assign af_o    = af_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace buffer: captures committed register writes from the CPU
// debug port, tags them with a sequence number and streams them out over
// valid/ready. Dropped commits are counted and flagged sticky.
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   enable, clear                 capture gate, synchronous flush
//   wb_pc/rf_wen/rf_addr/rf_wdata writeback debug port
//   trace_valid/ready             output stream handshake (FWFT)
//   trace_pc/addr/wdata/seq       head entry, zero when empty
//   count, almost_full            occupancy and early-warning flag
//   overflow, drop_cnt            sticky drop flag and saturating drop count
module wb_trace_buffer
    import wb_trace_buffer_pkg::*;
#(
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned AF_MARGIN = 2,
    parameter bit          FILTER_R0 = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear,
    input  logic [TRACE_PC_W-1:0]     wb_pc,
    input  logic                      wb_rf_wen,
    input  logic [TRACE_ADDR_W-1:0]   wb_rf_addr,
    input  logic [TRACE_DATA_W-1:0]   wb_rf_wdata,
    output logic                      trace_valid,
    input  logic                      trace_ready,
    output logic [TRACE_PC_W-1:0]     trace_pc,
    output logic [TRACE_ADDR_W-1:0]   trace_addr,
    output logic [TRACE_DATA_W-1:0]   trace_wdata,
    output logic [TRACE_SEQ_W-1:0]    trace_seq,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      almost_full,
    output logic                      overflow,
    output logic [15:0]               drop_cnt
);

    trace_entry_t              push_entry;
    trace_entry_t              head_entry;
    logic [TRACE_ENTRY_W-1:0]  head_raw;
    logic                      capture;
    logic                      fifo_full;
    logic                      drop;
    logic [TRACE_SEQ_W-1:0]    seq_q, seq_d;
    logic                      overflow_q, overflow_d;
    logic [15:0]               drop_cnt_q, drop_cnt_d;

    assign capture = capture_ok(enable, wb_rf_wen, wb_rf_addr, FILTER_R0);

    assign push_entry = '{pc: wb_pc, addr: wb_rf_addr, wdata: wb_rf_wdata, seq: seq_q};

    // Full with no pop this cycle means the commit has nowhere to go
    assign drop = capture & ~clear & fifo_full & ~(trace_valid & trace_ready);

    wb_trace_buffer_sync_fifo #(
        .DEPTH    (DEPTH),
        .WIDTH    (TRACE_ENTRY_W),
        .AF_LEVEL (DEPTH - AF_MARGIN)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (clear),
        .push_i  (capture),
        .wdata_i (push_entry),
        .pop_i   (trace_ready),
        .valid_o (trace_valid),
        .rdata_o (head_raw),
        .full_o  (fifo_full),
        .af_o    (almost_full),
        .count_o (count)
    );

    // Sequence advances on every capture, dropped or not, so gaps are visible
    always_comb begin
        seq_d      = seq_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (clear) begin
            seq_d      = '0;
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end else begin
            if (capture) seq_d = seq_q + TRACE_SEQ_W'(1);
            if (drop) begin
                overflow_d = 1'b1;
                if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seq_q      <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            seq_q      <= seq_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign head_entry  = trace_entry_t'(head_raw);
    assign trace_pc    = head_entry.pc;
    assign trace_addr  = head_entry.addr;
    assign trace_wdata = head_entry.wdata;
    assign trace_seq   = head_entry.seq;
    assign overflow    = overflow_q;
    assign drop_cnt    = drop_cnt_q;

endmodule
